// File: rtl/wb_sram_slave_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  wbsramDef : shared types for the Wishbone SRAM responder (FSM state, request)
//  Revision  : 1.0
// ----------------------------------------------------------------------------
package wbsramDef;

   localparam int IDX_W = 30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             we;
      logic [3:0]       sel;
      logic [31:0]      dat;
      logic             oor;
   } req_t;

endpackage
`default_nettype wire

// File: rtl/wb_sram_slave_reqq.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  wb_reqq : synchronous request FIFO with flush, count, full and empty flags
//  Revision: 1.0
// ----------------------------------------------------------------------------
module wb_reqq
   import wbsramDef::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  req_t                   din_i,
   output req_t                   dout_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   req_t          mem_q [DEPTH];
   req_t          mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/wb_sram_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  wb_sram_slave : pipelined Wishbone B4 responder over a word-organised SRAM.
//  Optional macro WBSRAM_ERR_EN: out-of-range addresses complete with err_o.
//  Revision      : 1.0
// ----------------------------------------------------------------------------
module wb_sram_slave
   import wbsramDef::*;
#(
   parameter int AWIDTH   = 32,
   parameter int MEMWORDS = 4096,
   parameter int WAIT     = 1,
   parameter int QDEPTH   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] adr_i,
   input  logic [3:0]        sel_i,
   input  logic [31:0]       dat_i,
   output logic [31:0]       dat_o,
   output logic              ack_o,
   output logic              err_o,
   output logic              stall_o
);

   localparam int IW = $clog2(MEMWORDS);

   logic [31:0] ram [MEMWORDS];

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   req_t        cur_q, cur_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] dat_q, dat_d;

   req_t                    req_in, q_head;
   logic                    accept, pop, do_write, q_full, q_empty;
   logic [$clog2(QDEPTH):0] q_count;
   logic                    unused_ok;

   assign accept = cyc_i & stb_i & ~q_full;

   always_comb begin
      req_in     = '0;
      req_in.idx = IDX_W'(adr_i[IW+1:2]);
      req_in.we  = we_i;
      req_in.sel = sel_i;
      req_in.dat = dat_i;
`ifdef WBSRAM_ERR_EN
      req_in.oor = (adr_i >> (IW + 2)) != '0;
`else
      req_in.oor = 1'b0;
`endif
   end

   wb_reqq #(.DEPTH(QDEPTH)) u_reqq (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept),
      .pop_i   (pop),
      .flush_i (~cyc_i),
      .din_i   (req_in),
      .dout_o  (q_head),
      .count_o (q_count),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   // IDLE and RESP share the dispatch rule: pop the head if one is waiting.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cur_d    = cur_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = dat_q;
      pop      = 1'b0;
      do_write = 1'b0;
      if (!cyc_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_RESP: begin
               if (!q_empty) begin
                  pop     = 1'b1;
                  cur_d   = q_head;
                  cnt_d   = 3'(WAIT);
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (cnt_q != 3'd0) begin
                  cnt_d = cnt_q - 3'd1;
               end else begin
                  state_d = ST_RESP;
                  if (cur_q.oor) begin
                     err_d = 1'b1;
                  end else begin
                     ack_d = 1'b1;
                     if (cur_q.we) do_write = 1'b1;
                     else          dat_d    = ram[cur_q.idx[IW-1:0]];
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         cur_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_write && !rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_q.sel[b]) ram[cur_q.idx[IW-1:0]][8*b +: 8] <= cur_q.dat[8*b +: 8];
         end
      end
   end

   assign dat_o     = dat_q;
   assign ack_o     = ack_q;
   assign err_o     = err_q;
   assign stall_o   = q_full;
   assign unused_ok = ^{adr_i, cur_q.idx, q_count};

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  tb_wb_sram_slave : self-checking bench for wb_sram_slave (WAIT=1, QDEPTH=2)
//  Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_wb_sram_slave;

   localparam int WAIT = 1;

   logic        clk_i = 1'b0;
   logic        rst_i, cyc_i, stb_i, we_i;
   logic [31:0] adr_i, dat_i, dat_o;
   logic [3:0]  sel_i;
   logic        ack_o, err_o, stall_o;

   wb_sram_slave #(.AWIDTH(32), .MEMWORDS(4096), .WAIT(WAIT), .QDEPTH(2)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cyc_i   (cyc_i),
      .stb_i   (stb_i),
      .we_i    (we_i),
      .adr_i   (adr_i),
      .sel_i   (sel_i),
      .dat_i   (dat_i),
      .dat_o   (dat_o),
      .ack_o   (ack_o),
      .err_o   (err_o),
      .stall_o (stall_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        chk;
      logic [31:0] dat;
      logic        err;
      int unsigned cyc;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] xdat;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        tbl[13];
   int unsigned cycle_cnt = 0;
   int unsigned last_exp  = 0;
   int          total     = 0;
   int          bad       = 0;

   always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

   // Every completion is matched in order against the scoreboard head.
   always @(negedge clk_i) begin
      if (ack_o || err_o) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_completion ack=%0b err=%0b required none", ack_o, err_o);
         end else begin
            mon_e = sb.pop_front();
            if ({err_o, ack_o} !== {mon_e.err, !mon_e.err}) begin
               bad++;
               $display("FAIL kind ack/err=%b%b required=%b%b", ack_o, err_o, !mon_e.err, mon_e.err);
            end
            total++;
            if (cycle_cnt != mon_e.cyc) begin
               bad++;
               $display("FAIL latency cycle=%0d required=%0d", cycle_cnt, mon_e.cyc);
            end
            if (mon_e.chk && !mon_e.err) begin
               total++;
               if (dat_o !== mon_e.dat) begin
                  bad++;
                  $display("FAIL rdata actual=%h required=%h", dat_o, mon_e.dat);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic beat(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [31:0] xdat, input logic xerr);
      exp_t e;
      int   n;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
      n = 0;
      while (stall_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (stall_o) begin
         total++;
         bad++;
         $display("FAIL stall_timeout stall=%0b required=0", stall_o);
      end else begin
         e.chk = !we;
         e.dat = xdat;
         e.err = xerr;
         e.cyc = cycle_cnt + 3 + WAIT;
         if (last_exp + WAIT + 2 > e.cyc) e.cyc = last_exp + WAIT + 2;
         last_exp = e.cyc;
         sb.push_back(e);
      end
      @(negedge clk_i);
      stb_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout pending=%0d required=0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 32'h0000_0010, 4'hf, 32'hDEAD_BEEF, 32'h0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 4'hf, 32'h0,         32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 32'h0000_0000, 4'hf, 32'hAAAA_AAAA, 32'h0};
      tbl[3]  = '{1'b1, 32'h0000_0000, 4'h5, 32'h1122_3344, 32'h0};
      tbl[4]  = '{1'b0, 32'h0000_0003, 4'h0, 32'h0,         32'hAA22_AA44};
      tbl[5]  = '{1'b1, 32'h0000_0020, 4'hf, 32'hCAFE_F00D, 32'h0};
      tbl[6]  = '{1'b1, 32'h0000_0020, 4'h0, 32'h1234_5678, 32'h0};
      tbl[7]  = '{1'b0, 32'h0000_0020, 4'hf, 32'h0,         32'hCAFE_F00D};
      tbl[8]  = '{1'b1, 32'h0000_0024, 4'hf, 32'h0000_0000, 32'h0};
      tbl[9]  = '{1'b1, 32'h0000_0024, 4'ha, 32'hFFFF_FFFF, 32'h0};
      tbl[10] = '{1'b0, 32'h0000_0024, 4'hf, 32'h0,         32'hFF00_FF00};
      tbl[11] = '{1'b1, 32'h0000_3FFC, 4'hf, 32'h55AA_55AA, 32'h0};
      tbl[12] = '{1'b0, 32'h0000_3FFC, 4'hf, 32'h0,         32'h55AA_55AA};

      rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      adr_i = '0; sel_i = '0; dat_i = '0;
      repeat (3) @(negedge clk_i);
      check("reset_ack", 32'(ack_o), 32'h0);
      check("reset_err", 32'(err_o), 32'h0);
      check("reset_stall", 32'(stall_o), 32'h0);
      check("reset_dat", dat_o, 32'h0);
      rst_i = 1'b0;
      cyc_i = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 13; i++) begin
         beat(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, tbl[i].xdat, 1'b0);
         wait_idle();
      end

`ifdef WBSRAM_ERR_EN
      beat(1'b0, 32'h0001_0000, 4'hf, 32'h0, 32'h0, 1'b1);
      wait_idle();
      check("err_dat_hold", dat_o, 32'h55AA_55AA);
`else
      beat(1'b0, 32'h0001_0000, 4'hf, 32'h0, 32'hAA22_AA44, 1'b0);
      wait_idle();
`endif

      // Back-to-back reads: the queue fills and stall_o rises.
      beat(1'b0, 32'h0000_0010, 4'hf, 32'h0, 32'hDEAD_BEEF, 1'b0);
      beat(1'b0, 32'h0000_0000, 4'h1, 32'h0, 32'hAA22_AA44, 1'b0);
      beat(1'b0, 32'h0000_0024, 4'hf, 32'h0, 32'hFF00_FF00, 1'b0);
      check("pipe_stall", 32'(stall_o), 32'h1);
      wait_idle();

      // Abort: two queued writes discarded by dropping cyc_i.
      beat(1'b1, 32'h0000_0040, 4'hf, 32'h0101_0101, 32'h0, 1'b0);
      beat(1'b1, 32'h0000_0044, 4'hf, 32'h0202_0202, 32'h0, 1'b0);
      wait_idle();
      beat(1'b1, 32'h0000_0040, 4'hf, 32'hBAD0_BAD0, 32'h0, 1'b0);
      beat(1'b1, 32'h0000_0044, 4'hf, 32'hBAD0_BAD0, 32'h0, 1'b0);
      cyc_i = 1'b0;
      sb.delete();
      last_exp = 0;
      @(negedge clk_i);
      check("abort_stall", 32'(stall_o), 32'h0);
      cyc_i = 1'b1;
      repeat (6) @(negedge clk_i);
      beat(1'b0, 32'h0000_0040, 4'hf, 32'h0, 32'h0101_0101, 1'b0);
      beat(1'b0, 32'h0000_0044, 4'hf, 32'h0, 32'h0202_0202, 1'b0);
      wait_idle();

      // Reset while an access is waiting in BUSY.
      beat(1'b0, 32'h0000_0010, 4'hf, 32'h0, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      sb.delete();
      last_exp = 0;
      @(negedge clk_i);
      check("rst_busy_ack", 32'(ack_o), 32'h0);
      check("rst_busy_err", 32'(err_o), 32'h0);
      check("rst_busy_stall", 32'(stall_o), 32'h0);
      check("rst_busy_dat", dat_o, 32'h0);
      rst_i = 1'b0;
      repeat (8) @(negedge clk_i);
      beat(1'b0, 32'h0000_0010, 4'hf, 32'h0, 32'hDEAD_BEEF, 1'b0);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
